// File: rtl/qam_pkg.sv
// Shared widths, defaults and state encoding for the QAM symbol scheduler.
package qam_pkg;

  localparam int SYM_W        = 6;
  localparam int RATE_W       = 4;
  localparam int DEFAULT_RATE = 13;
  localparam int LEN_W        = 16;
  localparam int FIFO_DEPTH   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/qam_sym_fifo.sv
// Small synchronous symbol FIFO with flush; read data is shown from the head entry.
module qam_sym_fifo
  import qam_pkg::*;
#(
  parameter int W     = SYM_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // pointer update
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/qam_symbol_scheduler.sv
// Releases one buffered 64-QAM symbol every R clocks (zeros in between) for
// N-symbol frames, flagging slots that find the buffer empty.
module qam_symbol_scheduler
  import qam_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [SYM_W-1:0]  s_data,
  output logic              s_ready,
  output logic [SYM_W-1:0]  sym_out,
  output logic              sym_strobe,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  state_t            state;
  state_t            next_state;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] phase;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  remaining_next;
  logic              accept;
  logic              slot;
  logic              last_phase;
  logic              frame_end;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SYM_W-1:0]  fifo_dout;

  assign s_ready   = !fifo_full && !rst;
  assign fifo_push = s_valid && s_ready && !abort;
  assign busy      = (state == RUN);

  qam_sym_fifo #(.W(SYM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (fifo_push),
    .din   (s_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // next-state and slot decode
  always_comb begin
    next_state     = state;
    accept         = 1'b0;
    slot           = 1'b0;
    last_phase     = 1'b0;
    frame_end      = 1'b0;
    fifo_pop       = 1'b0;
    remaining_next = remaining;
    case (state)
      IDLE: begin
        accept = start && !abort && (cfg_rate != {RATE_W{1'b0}}) && (frame_len != {LEN_W{1'b0}});
        if (accept) next_state = RUN;
        else        next_state = IDLE;
      end
      RUN: begin
        slot       = (phase == {RATE_W{1'b0}});
        last_phase = (phase == rate_q - RATE_W'(1));
        // Use the post-slot count so R=1 frames end on their final slot.
        if (slot && (remaining != {LEN_W{1'b0}})) remaining_next = remaining - LEN_W'(1);
        else                                      remaining_next = remaining;
        frame_end = last_phase && (remaining_next == {LEN_W{1'b0}});
        fifo_pop  = slot && !fifo_empty && !abort;
        if (abort || frame_end) next_state = IDLE;
        else                    next_state = RUN;
      end
      default: next_state = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q     <= RATE_W'(DEFAULT_RATE);
      phase      <= {RATE_W{1'b0}};
      remaining  <= {LEN_W{1'b0}};
      sym_out    <= {SYM_W{1'b0}};
      sym_strobe <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else if (abort) begin
      phase      <= {RATE_W{1'b0}};
      remaining  <= {LEN_W{1'b0}};
      sym_out    <= {SYM_W{1'b0}};
      sym_strobe <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      sym_out    <= fifo_pop ? fifo_dout : {SYM_W{1'b0}};
      sym_strobe <= slot;
      underrun   <= slot && fifo_empty;
      done       <= frame_end;
      if (accept) begin
        rate_q    <= cfg_rate;
        remaining <= frame_len;
        phase     <= {RATE_W{1'b0}};
      end else if (state == RUN) begin
        remaining <= remaining_next;
        phase     <= last_phase ? {RATE_W{1'b0}} : phase + RATE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Scoreboard bench: stimulus queues hand-computed output events, a negedge monitor pops and compares.
module tb_qam_symbol_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_rate;
  logic [15:0] frame_len;
  logic        start;
  logic        abort;
  logic        s_valid;
  logic [5:0]  s_data;
  logic        s_ready;
  logic [5:0]  sym_out;
  logic        sym_strobe;
  logic        busy;
  logic        done;
  logic        underrun;

  typedef struct {
    int         cyc;
    logic [5:0] sym;
    logic       strobe;
    logic       und;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  int   t       = 0;
  bit   mon_en  = 1'b0;

  qam_symbol_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_rate   (cfg_rate),
    .frame_len  (frame_len),
    .start      (start),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .sym_out    (sym_out),
    .sym_strobe (sym_strobe),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_ev(input int c, input logic [5:0] s, input logic st, input logic u, input logic d);
    exp_t e;
    e.cyc = c; e.sym = s; e.strobe = st; e.und = u; e.dn = d;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic flush();
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
  endtask

  task automatic push1(input logic [5:0] d);
    tick(); s_valid = 1'b1; s_data = d;
    tick(); s_valid = 1'b0;
  endtask

  // Leaves the caller at the negedge of cycle t+1 with start dropped.
  task automatic launch(input logic [3:0] r, input logic [15:0] n);
    tick();
    cfg_rate = r; frame_len = n; start = 1'b1; t = cyc;
    if (r != 4'd0 && n != 16'd0) begin
      busy_lo = t + 1;
      busy_hi = t + int'(n) * int'(r);
    end
    tick(); start = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      if (!sym_strobe) chk("zero_stuff", int'(sym_out), 0);
      if (sym_strobe || done || underrun) begin
        if (sb.size() == 0) begin
          chk("unexpected_event_cycle", cyc, -1);
        end else begin
          mon_e = sb.pop_front();
          chk("event_cycle", cyc, mon_e.cyc);
          chk("sym_out", int'(sym_out), int'(mon_e.sym));
          chk("sym_strobe", int'(sym_strobe), int'(mon_e.strobe));
          chk("underrun", int'(underrun), int'(mon_e.und));
          chk("done", int'(done), int'(mon_e.dn));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_rate = 4'd0; frame_len = 16'd0; start = 1'b0;
    abort = 1'b0; s_valid = 1'b0; s_data = 6'd0;
    repeat (3) tick();
    chk("rst_sym_out", int'(sym_out), 0);
    chk("rst_sym_strobe", int'(sym_strobe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    rst = 1'b0;
    tick();
    chk("s_ready_after_rst", int'(s_ready), 1);
    mon_en = 1'b1;

    // 1: R=4 N=3 prefilled
    flush();
    push1(6'd5); push1(6'd9); push1(6'd63);
    launch(4'd4, 16'd3);
    exp_ev(t + 2, 6'd5, 1'b1, 1'b0, 1'b0);
    exp_ev(t + 6, 6'd9, 1'b1, 1'b0, 1'b0);
    exp_ev(t + 10, 6'd63, 1'b1, 1'b0, 1'b0);
    exp_ev(t + 13, 6'd0, 1'b0, 1'b0, 1'b1);
    wait_until(t + 16);

    // 2: R=13 N=2, empty FIFO
    flush();
    launch(4'd13, 16'd2);
    exp_ev(t + 2, 6'd0, 1'b1, 1'b1, 1'b0);
    exp_ev(t + 15, 6'd0, 1'b1, 1'b1, 1'b0);
    exp_ev(t + 27, 6'd0, 1'b0, 1'b0, 1'b1);
    wait_until(t + 30);

    // 3: R=1 N=4, push every cycle from the first slot on (no bypass)
    flush();
    launch(4'd1, 16'd4);
    exp_ev(t + 2, 6'd0, 1'b1, 1'b1, 1'b0);
    exp_ev(t + 3, 6'd21, 1'b1, 1'b0, 1'b0);
    exp_ev(t + 4, 6'd22, 1'b1, 1'b0, 1'b0);
    exp_ev(t + 5, 6'd23, 1'b1, 1'b0, 1'b1);
    s_valid = 1'b1; s_data = 6'd21;
    tick(); s_data = 6'd22;
    tick(); s_data = 6'd23;
    tick(); s_data = 6'd24;
    tick(); s_valid = 1'b0;
    wait_until(t + 8);

    // 4: fill to full with s_valid held, 5th symbol waits for a pop
    flush();
    for (int i = 0; i < 4; i++) begin
      tick();
      s_valid = 1'b1; s_data = 6'(10 + i);
      chk("fill_s_ready", int'(s_ready), 1);
    end
    tick(); s_data = 6'd14;
    chk("full_s_ready", int'(s_ready), 0);
    tick();
    chk("full_s_ready_hold", int'(s_ready), 0);
    launch(4'd2, 16'd5);
    exp_ev(t + 2, 6'd10, 1'b1, 1'b0, 1'b0);
    exp_ev(t + 4, 6'd11, 1'b1, 1'b0, 1'b0);
    exp_ev(t + 6, 6'd12, 1'b1, 1'b0, 1'b0);
    exp_ev(t + 8, 6'd13, 1'b1, 1'b0, 1'b0);
    exp_ev(t + 10, 6'd14, 1'b1, 1'b0, 1'b0);
    exp_ev(t + 11, 6'd0, 1'b0, 1'b0, 1'b1);
    chk("full_before_pop", int'(s_ready), 0);
    tick();
    chk("ready_after_pop", int'(s_ready), 1);
    tick(); s_valid = 1'b0;
    wait_until(t + 14);

    // 5: abort on the 2nd phase-0 of R=4 N=8, push in the same cycle is dropped
    flush();
    push1(6'd1); push1(6'd2); push1(6'd3); push1(6'd4);
    launch(4'd4, 16'd8);
    exp_ev(t + 2, 6'd1, 1'b1, 1'b0, 1'b0);
    wait_until(t + 5);
    abort = 1'b1; s_valid = 1'b1; s_data = 6'd7; busy_hi = t + 5;
    tick(); abort = 1'b0; s_valid = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_strobe", int'(sym_strobe), 0);
    tick();
    launch(4'd1, 16'd1);
    exp_ev(t + 2, 6'd0, 1'b1, 1'b1, 1'b1);
    wait_until(t + 5);

    // 6: zero rate or zero length is ignored
    launch(4'd0, 16'd5);
    repeat (4) tick();
    launch(4'd3, 16'd0);
    repeat (4) tick();
    chk("ignored_start_busy", int'(busy), 0);

    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
